// File: rtl/adc_receiver.sv
// adc_receiver: I2S ADC capture into a valid/ready FIFO of left/right sample pairs.
// Define ADC_RX_MONO_EN to add MONO_OUT, the halved signed L+R sum of the head pair.
module adc_receiver #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              AUD_BCLK,
    input  logic              AUD_ADCLRCK,
    input  logic              AUD_ADCDAT,
    input  logic              Enable,
    output logic [DATA_W-1:0] LDATA_OUT,
    output logic [DATA_W-1:0] RDATA_OUT,
    output logic              valid,
    input  logic              ready,
    output logic              overflow,
    input  logic              overflow_clr,
    output logic              frame_err
`ifdef ADC_RX_MONO_EN
    ,
    output logic [DATA_W-1:0] MONO_OUT
`endif
);
    localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned      BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;
    typedef enum logic {CH_L, CH_R} ch_t;

    logic bclk_s1, bclk_s2, bclk_s3, lrck_s1, lrck_s2, dat_s1, dat_s2, lrck_prev;
    logic bclk_rise, lrck_fall, lrck_rise;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bclk_s1   <= 1'b0;
            bclk_s2   <= 1'b0;
            bclk_s3   <= 1'b0;
            lrck_s1   <= 1'b0;
            lrck_s2   <= 1'b0;
            dat_s1    <= 1'b0;
            dat_s2    <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_s1 <= AUD_BCLK;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            lrck_s1 <= AUD_ADCLRCK;
            lrck_s2 <= lrck_s1;
            dat_s1  <= AUD_ADCDAT;
            dat_s2  <= dat_s1;
            if (bclk_rise) lrck_prev <= lrck_s2;
        end
    end

    assign bclk_rise = bclk_s2 & ~bclk_s3;
    assign lrck_fall = bclk_rise & lrck_prev & ~lrck_s2;
    assign lrck_rise = bclk_rise & ~lrck_prev & lrck_s2;

    state_t            state, state_n;
    ch_t               ch, ch_n;
    logic [BIT_W-1:0]  bitcnt, bitcnt_n;
    logic [DATA_W-2:0] shreg, shreg_n;
    logic [DATA_W-1:0] hold_l, hold_l_n, word;
    logic              hold_ok, hold_ok_n, push, trunc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            ch        <= CH_L;
            bitcnt    <= '0;
            shreg     <= '0;
            hold_l    <= '0;
            hold_ok   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            ch        <= ch_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            hold_l    <= hold_l_n;
            hold_ok   <= hold_ok_n;
            frame_err <= trunc;
        end
    end

    // The LRCK edge is seen on the delay-bit rise itself, so SKIP only lasts one
    // Clk cycle and SHIFT samples the MSB on the following rise.
    always_comb begin
        state_n   = state;
        ch_n      = ch;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        hold_l_n  = hold_l;
        hold_ok_n = hold_ok;
        push      = 1'b0;
        trunc     = 1'b0;
        word      = {shreg, dat_s2};
        if (!Enable) begin
            state_n   = IDLE;
            hold_ok_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (lrck_fall) begin
                    state_n   = SKIP;
                    ch_n      = CH_L;
                    hold_ok_n = 1'b0;
                end
                SKIP: begin
                    state_n  = SHIFT;
                    bitcnt_n = '0;
                end
                SHIFT: if (lrck_fall || lrck_rise) begin
                    trunc     = 1'b1;
                    hold_ok_n = 1'b0;
                    ch_n      = CH_L;
                    state_n   = lrck_fall ? SKIP : IDLE;
                end else if (bclk_rise) begin
                    shreg_n  = word[DATA_W-2:0];
                    bitcnt_n = bitcnt + BIT_W'(1);
                    if (bitcnt == LAST_BIT) begin
                        state_n = WAIT;
                        if (ch == CH_L) begin
                            hold_l_n  = word;
                            hold_ok_n = 1'b1;
                        end else begin
                            push      = hold_ok;
                            hold_ok_n = 1'b0;
                        end
                    end
                end
                WAIT: if (lrck_fall || lrck_rise) begin
                    ch_n    = (ch == CH_L) ? CH_R : CH_L;
                    state_n = SKIP;
                    if (ch == CH_R) hold_ok_n = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0]  count, count_n;
    logic [DATA_W-1:0] head_l, head_r;
    logic              pop, full, do_push, ovf_set;

    assign pop     = valid & ready;
    assign full    = (count == FULL_CNT);
    assign do_push = push & (~full | pop);
    assign ovf_set = push & full & ~pop;
    assign rd_next = rd_ptr + PTR_W'(1);

    always_comb begin
        count_n = count;
        if (do_push && !pop)      count_n = count + CNT_W'(1);
        else if (!do_push && pop) count_n = count - CNT_W'(1);
    end

    // Registered head: refilled from the incoming pair when the FIFO is (or becomes) empty.
    always_comb begin
        head_l = LDATA_OUT;
        head_r = RDATA_OUT;
        if (count == '0 || (pop && count == CNT_W'(1))) begin
            if (do_push) begin
                head_l = hold_l;
                head_r = word;
            end
        end else if (pop) begin
            head_l = mem_l[rd_next];
            head_r = mem_r[rd_next];
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_l[wr_ptr] <= hold_l;
            mem_r[wr_ptr] <= word;
        end
    end

`ifdef ADC_RX_MONO_EN
    logic signed [DATA_W:0] mono_sum;
    assign mono_sum = $signed({head_l[DATA_W-1], head_l}) + $signed({head_r[DATA_W-1], head_r});
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            LDATA_OUT <= '0;
            RDATA_OUT <= '0;
`ifdef ADC_RX_MONO_EN
            MONO_OUT  <= '0;
`endif
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_next;
            count     <= count_n;
            valid     <= (count_n != '0);
            if (overflow_clr) overflow <= 1'b0;
            else if (ovf_set) overflow <= 1'b1;
            LDATA_OUT <= head_l;
            RDATA_OUT <= head_r;
`ifdef ADC_RX_MONO_EN
            MONO_OUT  <= DATA_W'(mono_sum >>> 1);
`endif
        end
    end
endmodule

// File: doc/adc_receiver.md
# adc_receiver

Capture block for the codec ADC path: receives the serial I2S stream on AUD_ADCDAT/AUD_BCLK/AUD_ADCLRCK and turns it into parallel 16-bit left/right sample pairs in the CLOCK_50 domain. Pairs are buffered in a small FIFO and offered with a valid/ready handshake to downstream consumers such as the filter, voice mixer or a NIOS PIO. It is the receive counterpart of the DAC transmit path that feeds LDATA/RDATA to the codec.

## Interface
- DATA_W, 16: bits per channel word captured.
- FIFO_DEPTH, 4: sample-pair entries. Power of 2, ≥2.
- Clk  in  1  system clock (CLOCK_50); all logic on its rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- AUD_BCLK  in  1  codec bit clock, asynchronous to Clk.
- AUD_ADCLRCK  in  1  codec ADC word clock: low = left, high = right.
- AUD_ADCDAT  in  1  codec serial data, MSB first.
- Enable  in  1  capture enable.
- LDATA_OUT  out  DATA_W  left sample at FIFO head.
- RDATA_OUT  out  DATA_W  right sample at FIFO head.
- valid  out  1  FIFO not empty.
- ready  in  1  consumer accepts the head pair on valid && ready.
- overflow  out  1  sticky: a pair was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.
- frame_err  out  1  one-cycle pulse: word truncated by an early LRCK edge.

## Operation
- AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT each pass through a 2-FF synchronizer.
- BCLK gets one extra delay stage. bclk_rise = s2 & ~s3.
- All capture actions occur only on Clk cycles where bclk_rise = 1.
- I2S format: the MSB is on the 2nd BCLK rising edge after an LRCK transition.
- FSM states:
  - IDLE: wait for the first LRCK falling edge (start of left word). Go to SKIP with ch = L.
  - SKIP: consume one BCLK rise (the I2S delay bit). Go to SHIFT with bitcnt = 0.
  - SHIFT: shreg <= {shreg[DATA_W-2:0], dat}; bitcnt++.
    - When bitcnt reaches DATA_W-1, store the word: left into hold_l; right triggers a FIFO push of {hold_l, word}.
    - Then go to WAIT.
  - WAIT: ignore the remaining bits. On an LRCK edge, toggle ch and go to SKIP.
- LRCK edges are evaluated on bclk_rise cycles using the synchronized LRCK versus its value at the previous bclk_rise.
- Truncated word: an LRCK edge while in SHIFT.
  - frame_err pulses for one cycle.
  - The word and any held left word are discarded, so no pair is pushed.
  - If the edge is falling, go to SKIP with ch = L; if rising, go to IDLE.
- A right word is only pushed if it was preceded by a complete left word of the same frame.
- Enable = 0:
  - FSM forced to IDLE, partial data discarded.
  - FIFO keeps its contents and still drains via ready.
- FIFO behaviour:
  - Circular, with count in 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - Push when full with no pop: the new pair is dropped and overflow is set.
  - Push and pop in the same cycle when full: both occur, overflow unchanged.
  - Push and pop in the same cycle when empty: the push occurs; the pop is ignored because valid = 0.
- overflow: overflow_clr has priority over a same-cycle set.
- Data is two's complement and passed through bit-exact, no scaling.

## Timing
- Reset values: LDATA_OUT = 0, RDATA_OUT = 0, valid = 0, overflow = 0, frame_err = 0, FSM = IDLE, FIFO empty.
- BCLK high and low phases must each last ≥3 Clk periods. The DE2 codec at ~3 MHz BCLK meets this.
- Latency: the push happens on the 3rd Clk edge after the last-bit BCLK rising edge reaches the pin (+1 for synchronizer uncertainty). valid rises right after that edge.
- Outputs are registered. The head pair is stable while valid = 1 and ready = 0.
- The next head pair appears on the Clk edge following a pop.
- Reset_n asserted mid-frame: everything returns to reset values immediately (asynchronous). After release, capture resumes at the next LRCK falling edge.

## Configuration
- ADC_RX_MONO_EN defined: adds output MONO_OUT [DATA_W-1:0], registered with the head pair, reset 0.
  - Value is bits [DATA_W:1] of the (DATA_W+1)-bit signed sum of LDATA_OUT and RDATA_OUT.
- Undefined: no MONO_OUT port and no adder.

## Test plan
- Reset release, then one I2S frame with L = 16'h8001, R = 16'h7FFE, ready = 1 -> one valid pulse; LDATA_OUT = 8001, RDATA_OUT = 7FFE; frame_err = 0.
- Five frames (L = 1..5, R = 16'h0100..16'h0104) with ready = 0 -> four pairs stored, overflow = 1. Then ready = 1 pops L = 1..4 in order; pair 5 is lost.
- Full FIFO with ready = 1 on the exact cycle of the 5th push -> overflow stays 0; all five pairs are delivered.
- LRCK rises after 10 left bits -> frame_err pulses once and no pair is pushed. The next complete frame (L = 16'h1234, R = 16'h5678) is delivered intact.
- Reset_n low mid-right-word while valid = 1 -> valid = 0 and outputs = 0 immediately. The first frame after release is captured correctly.
- ADC_RX_MONO_EN, L = 16'h7FFF, R = 16'h7FFF -> MONO_OUT = 7FFF. L = 16'h8000, R = 16'h7FFF -> MONO_OUT = FFFF.
